flash_arbiter: RTL and testbench
================================

FLASH_ARBITER -- requirements
Module: flash_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, selects the arbitration policy: 1 = round-robin, 0 = fixed priority with r0 winning.
REQ-002 sys_clk  in  1  clock; sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-003 rN_erase_all_i, rN_erase_64k_i, rN_erase_32k_i, rN_erase_4k_i, rN_wr_en_i, rN_rd_en_i  in  1 each  command strobes from requester N (N = 0, 1), held high until accepted.
REQ-004 rN_addr_i  in  24  flash address from requester N.
REQ-005 rN_wr_data_i  in  8  page-program data from requester N.
REQ-006 rN_busy_o  out  1  flash busy as seen by requester N.
REQ-007 rN_wr_req_o  out  1  write-data request to requester N.
REQ-008 rN_rd_data_o  out  8  read data to requester N.
REQ-009 rN_rd_data_valid_o  out  1  read-data qualifier to requester N.
REQ-010 rN_erase_done_o, rN_wr_done_o, rN_rd_done_o  out  1 each  completion pulses to requester N.
REQ-011 flash_erase_all_o, flash_erase_64k_o, flash_erase_32k_o, flash_erase_4k_o, flash_wr_en_o, flash_rd_en_o  out  1 each  command strobes to the flash controller.
REQ-012 flash_addr_o  out  24  address to the flash controller; flash_wr_data_o  out  8  write data to the flash controller.
REQ-013 flash_busy_i, flash_wr_req_i, flash_rd_data_valid_i, flash_erase_done_i, flash_wr_done_i, flash_rd_done_i  in  1 each  flash controller status.
REQ-014 flash_rd_data_i  in  8  read data from the flash controller.

Function
REQ-015 Requester N shall be "requesting" when any of its six command strobes is high.
REQ-016 The FSM shall have four states: IDLE, ISSUE, WAIT_DONE, RELEASE.
- IDLE -> ISSUE when any requester is requesting.
- ISSUE -> WAIT_DONE when the forwarded strobe is high and flash_busy_i = 0 (command accepted).
- ISSUE -> IDLE when the owner drops all strobes before acceptance.
- WAIT_DONE -> RELEASE on any flash_*_done_i pulse.
- RELEASE -> IDLE after exactly one cycle.
REQ-017 The owner register shall load on the IDLE -> ISSUE edge.
- A single requester shall win outright.
- When both request with RR_EN = 1, the requester other than last_owner shall win.
- When both request with RR_EN = 0, r0 shall win.
REQ-018 last_owner shall update to the owner on entry to RELEASE and shall reset to 1, so r0 wins the first tie.
REQ-019 In ISSUE, exactly one flash strobe shall be forwarded from the owner's strobes, in priority order erase_all > 64k > 32k > 4k > wr > rd; lower strobes asserted at the same time shall be ignored for that grant.
REQ-020 Flash strobes shall be combinational from the owner's inputs and be active only in ISSUE.
- They shall be low in every other state.
- A request sampled in IDLE at edge k shall reach the flash strobe in cycle k+1 (1-cycle latency).
REQ-021 flash_addr_o and flash_wr_data_o shall mux from the owner in ISSUE and WAIT_DONE, and shall be 0 in IDLE.
REQ-022 Busy reporting:
- rN_busy_o shall equal flash_busy_i for the owner in ISSUE and WAIT_DONE.
- rN_busy_o shall be 1 for the non-owner in ISSUE, WAIT_DONE and RELEASE.
- rN_busy_o shall be 1 for both requesters in RELEASE.
- rN_busy_o shall be 0 in IDLE.
REQ-023 flash_wr_req_i, flash_rd_data_valid_i and the three done pulses shall route only to the owner, with no added delay, and only in WAIT_DONE; they shall be dropped in all other states.
REQ-024 rN_rd_data_o shall equal flash_rd_data_i for both requesters.
REQ-025 A done pulse arriving in the same cycle as acceptance shall be ignored; the FSM shall go to WAIT_DONE.
REQ-026 A new request from the non-owner during WAIT_DONE shall be held off, and shall be granted in the IDLE that follows RELEASE.

Reset
REQ-027 On sys_rst_n low, the following shall clear asynchronously:
- state = IDLE, owner = 0, last_owner = 1.
- All outputs = 0.
REQ-028 Reset mid-operation shall abandon the grant; recovery of the flash controller is the controller's own responsibility.

Structure
REQ-029 A shared package flash_pkg shall hold:
- the state encoding (one-hot, 4 bits);
- the command-select priority encoding;
- the constant NUM_REQ = 2.
REQ-030 One sub-module, flash_cmd_prio, shall encode six strobes into a one-hot forwarded command.
- It shall be purely combinational.
- It shall be instantiated once, on the owner's strobes.

Verification
REQ-031 r0 erase_4k at addr 0x001000, flash_busy_i = 0 -> flash_erase_4k_o high 1 cycle later with flash_addr_o = 0x001000; then r0_erase_done_o pulses on done, and r1_busy_o = 1 throughout.
REQ-032 r0 and r1 both assert rd_en in the same cycle after reset, RR_EN = 1 -> r0 granted first; after its rd_done, r1 is granted; the next tie is won by r0.
REQ-033 RR_EN = 0, r0 and r1 continuously requesting -> r0 wins every grant and r1 is never granted.
REQ-034 r1 asserts wr_en and rd_en together -> only flash_wr_en_o is forwarded; 256 flash_wr_req_i pulses go to r1_wr_req_o only, with r1_wr_data_i passed through.
REQ-035 r0 drops its strobe in ISSUE while flash_busy_i = 1 -> returns to IDLE with no flash strobe accepted and no done pulse.
REQ-036 sys_rst_n pulsed low during WAIT_DONE -> all outputs 0 immediately; a stray flash_rd_done_i after reset is not routed to either requester.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared definitions for the flash arbiter: FSM state encoding,
// forwarded-command encoding and requester count.
package flash_pkg;

  localparam int NUM_REQ = 2;
  localparam int CMD_W   = 6;

  // One-hot arbiter states.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0001,
    ST_ISSUE     = 4'b0010,
    ST_WAIT_DONE = 4'b0100,
    ST_RELEASE   = 4'b1000
  } state_e;

  // Command vector layout, highest priority in the MSB:
  // {erase_all, erase_64k, erase_32k, erase_4k, wr_en, rd_en}.
  typedef logic [CMD_W-1:0] cmd_t;

  localparam cmd_t CMD_NONE      = 6'b000000;
  localparam cmd_t CMD_ERASE_ALL = 6'b100000;
  localparam cmd_t CMD_ERASE_64K = 6'b010000;
  localparam cmd_t CMD_ERASE_32K = 6'b001000;
  localparam cmd_t CMD_ERASE_4K  = 6'b000100;
  localparam cmd_t CMD_WR        = 6'b000010;
  localparam cmd_t CMD_RD        = 6'b000001;

endpackage

// File: rtl/flash_cmd_prio.sv
// Picks the single highest-priority strobe out of a requester's six
// command strobes and presents it as a one-hot command.
module flash_cmd_prio
  import flash_pkg::*;
(
  input  logic [CMD_W-1:0] cmd_req,
  output logic [CMD_W-1:0] cmd_sel
);

  // Priority pick: erase_all > 64k > 32k > 4k > wr > rd.
  always_comb begin
    cmd_sel = CMD_NONE;
    if ((cmd_req & CMD_ERASE_ALL) != CMD_NONE) begin
      cmd_sel = CMD_ERASE_ALL;
    end else if ((cmd_req & CMD_ERASE_64K) != CMD_NONE) begin
      cmd_sel = CMD_ERASE_64K;
    end else if ((cmd_req & CMD_ERASE_32K) != CMD_NONE) begin
      cmd_sel = CMD_ERASE_32K;
    end else if ((cmd_req & CMD_ERASE_4K) != CMD_NONE) begin
      cmd_sel = CMD_ERASE_4K;
    end else if ((cmd_req & CMD_WR) != CMD_NONE) begin
      cmd_sel = CMD_WR;
    end else if ((cmd_req & CMD_RD) != CMD_NONE) begin
      cmd_sel = CMD_RD;
    end else begin
      cmd_sel = CMD_NONE;
    end
  end

endmodule

// File: rtl/flash_arbiter.sv
// Two-requester arbiter in front of a single flash controller. One owner
// is granted at a time; its highest-priority command is forwarded while
// in ISSUE, and controller status is routed back to it until done.
module flash_arbiter
  import flash_pkg::*;
#(
  parameter logic RR_EN = 1'b1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        r0_erase_all_i,
  input  logic        r0_erase_64k_i,
  input  logic        r0_erase_32k_i,
  input  logic        r0_erase_4k_i,
  input  logic        r0_wr_en_i,
  input  logic        r0_rd_en_i,
  input  logic [23:0] r0_addr_i,
  input  logic [7:0]  r0_wr_data_i,
  output logic        r0_busy_o,
  output logic        r0_wr_req_o,
  output logic [7:0]  r0_rd_data_o,
  output logic        r0_rd_data_valid_o,
  output logic        r0_erase_done_o,
  output logic        r0_wr_done_o,
  output logic        r0_rd_done_o,
  input  logic        r1_erase_all_i,
  input  logic        r1_erase_64k_i,
  input  logic        r1_erase_32k_i,
  input  logic        r1_erase_4k_i,
  input  logic        r1_wr_en_i,
  input  logic        r1_rd_en_i,
  input  logic [23:0] r1_addr_i,
  input  logic [7:0]  r1_wr_data_i,
  output logic        r1_busy_o,
  output logic        r1_wr_req_o,
  output logic [7:0]  r1_rd_data_o,
  output logic        r1_rd_data_valid_o,
  output logic        r1_erase_done_o,
  output logic        r1_wr_done_o,
  output logic        r1_rd_done_o,
  output logic        flash_erase_all_o,
  output logic        flash_erase_64k_o,
  output logic        flash_erase_32k_o,
  output logic        flash_erase_4k_o,
  output logic        flash_wr_en_o,
  output logic        flash_rd_en_o,
  output logic [23:0] flash_addr_o,
  output logic [7:0]  flash_wr_data_o,
  input  logic        flash_busy_i,
  input  logic        flash_wr_req_i,
  input  logic        flash_rd_data_valid_i,
  input  logic        flash_erase_done_i,
  input  logic        flash_wr_done_i,
  input  logic        flash_rd_done_i,
  input  logic [7:0]  flash_rd_data_i
);

  state_e             state_r;
  state_e             state_nxt_s;
  logic               owner_r;
  logic               last_owner_r;
  logic               grant_s;
  logic [NUM_REQ-1:0] req_s;
  cmd_t               r0_cmd_s;
  cmd_t               r1_cmd_s;
  cmd_t               owner_cmd_s;
  cmd_t               cmd_sel_s;
  logic               done_any_s;
  logic               in_issue_s;
  logic               in_wait_s;
  logic               in_release_s;
  logic               route0_s;
  logic               route1_s;

  assign r0_cmd_s = {r0_erase_all_i, r0_erase_64k_i, r0_erase_32k_i,
                     r0_erase_4k_i, r0_wr_en_i, r0_rd_en_i};
  assign r1_cmd_s = {r1_erase_all_i, r1_erase_64k_i, r1_erase_32k_i,
                     r1_erase_4k_i, r1_wr_en_i, r1_rd_en_i};
  assign req_s       = {(r1_cmd_s != CMD_NONE), (r0_cmd_s != CMD_NONE)};
  assign owner_cmd_s = owner_r ? r1_cmd_s : r0_cmd_s;
  assign done_any_s  = flash_erase_done_i | flash_wr_done_i | flash_rd_done_i;

  flash_cmd_prio u_cmd_prio (
    .cmd_req (owner_cmd_s),
    .cmd_sel (cmd_sel_s)
  );

  // Grant decision for the next ownership, evaluated while IDLE.
  always_comb begin
    grant_s = 1'b0;
    if (req_s[0] && req_s[1]) begin
      if (RR_EN) begin
        grant_s = ~last_owner_r;
      end else begin
        grant_s = 1'b0;
      end
    end else if (req_s[1]) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Next-state logic; a done pulse coinciding with acceptance is ignored
  // because only WAIT_DONE looks at the done inputs.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s != 2'b00) state_nxt_s = ST_ISSUE;
        else                state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (owner_cmd_s == CMD_NONE) state_nxt_s = ST_IDLE;
        else if (!flash_busy_i)      state_nxt_s = ST_WAIT_DONE;
        else                         state_nxt_s = ST_ISSUE;
      end
      ST_WAIT_DONE: begin
        if (done_any_s) state_nxt_s = ST_RELEASE;
        else            state_nxt_s = ST_WAIT_DONE;
      end
      ST_RELEASE: state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // State, owner and round-robin history registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r      <= ST_IDLE;
      owner_r      <= 1'b0;
      last_owner_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == ST_IDLE) && (state_nxt_s == ST_ISSUE)) begin
        owner_r <= grant_s;
      end
      if ((state_r == ST_WAIT_DONE) && (state_nxt_s == ST_RELEASE)) begin
        last_owner_r <= owner_r;
      end
    end
  end

  assign in_issue_s   = (state_r == ST_ISSUE);
  assign in_wait_s    = (state_r == ST_WAIT_DONE);
  assign in_release_s = (state_r == ST_RELEASE);
  assign route0_s     = in_wait_s && (owner_r == 1'b0);
  assign route1_s     = in_wait_s && (owner_r == 1'b1);

  // Controller-facing command, address and write data.
  always_comb begin
    {flash_erase_all_o, flash_erase_64k_o, flash_erase_32k_o,
     flash_erase_4k_o, flash_wr_en_o, flash_rd_en_o} = CMD_NONE;
    flash_addr_o    = 24'h000000;
    flash_wr_data_o = 8'h00;
    if (in_issue_s) begin
      {flash_erase_all_o, flash_erase_64k_o, flash_erase_32k_o,
       flash_erase_4k_o, flash_wr_en_o, flash_rd_en_o} = cmd_sel_s;
    end else begin
      {flash_erase_all_o, flash_erase_64k_o, flash_erase_32k_o,
       flash_erase_4k_o, flash_wr_en_o, flash_rd_en_o} = CMD_NONE;
    end
    if (in_issue_s || in_wait_s) begin
      flash_addr_o    = owner_r ? r1_addr_i    : r0_addr_i;
      flash_wr_data_o = owner_r ? r1_wr_data_i : r0_wr_data_i;
    end else begin
      flash_addr_o    = 24'h000000;
      flash_wr_data_o = 8'h00;
    end
  end

  // Busy view: owner sees the controller, everyone else is held off.
  always_comb begin
    r0_busy_o = 1'b0;
    r1_busy_o = 1'b0;
    if (in_issue_s || in_wait_s) begin
      r0_busy_o = owner_r ? 1'b1 : flash_busy_i;
      r1_busy_o = owner_r ? flash_busy_i : 1'b1;
    end else if (in_release_s) begin
      r0_busy_o = 1'b1;
      r1_busy_o = 1'b1;
    end else begin
      r0_busy_o = 1'b0;
      r1_busy_o = 1'b0;
    end
  end

  assign r0_wr_req_o        = route0_s & flash_wr_req_i;
  assign r0_rd_data_valid_o = route0_s & flash_rd_data_valid_i;
  assign r0_erase_done_o    = route0_s & flash_erase_done_i;
  assign r0_wr_done_o       = route0_s & flash_wr_done_i;
  assign r0_rd_done_o       = route0_s & flash_rd_done_i;
  assign r1_wr_req_o        = route1_s & flash_wr_req_i;
  assign r1_rd_data_valid_o = route1_s & flash_rd_data_valid_i;
  assign r1_erase_done_o    = route1_s & flash_erase_done_i;
  assign r1_wr_done_o       = route1_s & flash_wr_done_i;
  assign r1_rd_done_o       = route1_s & flash_rd_done_i;
  assign r0_rd_data_o       = flash_rd_data_i;
  assign r1_rd_data_o       = flash_rd_data_i;

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench: a round-robin instance (u_rr) and a fixed-priority
// instance (u_fp) share all inputs; expectations are hand-derived.
module tb_flash_arbiter;

  logic sys_clk, sys_rst_n;
  logic r0_ea, r0_e64, r0_e32, r0_e4, r0_wr, r0_rd;
  logic r1_ea, r1_e64, r1_e32, r1_e4, r1_wr, r1_rd;
  logic [23:0] r0_addr, r1_addr;
  logic [7:0]  r0_wd, r1_wd, f_rdata;
  logic f_busy, f_wreq, f_rvalid, f_edone, f_wdone, f_rdone;

  // round-robin instance outputs
  logic a_r0_busy, a_r0_wreq, a_r0_rv, a_r0_ed, a_r0_wd, a_r0_rdn;
  logic a_r1_busy, a_r1_wreq, a_r1_rv, a_r1_ed, a_r1_wd, a_r1_rdn;
  logic [7:0] a_r0_rdata, a_r1_rdata, a_wdata;
  logic a_ea, a_e64, a_e32, a_e4, a_wr, a_rd;
  logic [23:0] a_addr;
  // fixed-priority instance outputs
  logic b_r0_busy, b_r0_wreq, b_r0_rv, b_r0_ed, b_r0_wd, b_r0_rdn;
  logic b_r1_busy, b_r1_wreq, b_r1_rv, b_r1_ed, b_r1_wd, b_r1_rdn;
  logic [7:0] b_r0_rdata, b_r1_rdata, b_wdata;
  logic b_ea, b_e64, b_e32, b_e4, b_wr, b_rd;
  logic [23:0] b_addr;

  logic [65:0] out_a, out_b;
  assign out_a = {a_ea, a_e64, a_e32, a_e4, a_wr, a_rd, a_addr, a_wdata,
                  a_r0_busy, a_r0_wreq, a_r0_rdata, a_r0_rv, a_r0_ed, a_r0_wd, a_r0_rdn,
                  a_r1_busy, a_r1_wreq, a_r1_rdata, a_r1_rv, a_r1_ed, a_r1_wd, a_r1_rdn};
  assign out_b = {b_ea, b_e64, b_e32, b_e4, b_wr, b_rd, b_addr, b_wdata,
                  b_r0_busy, b_r0_wreq, b_r0_rdata, b_r0_rv, b_r0_ed, b_r0_wd, b_r0_rdn,
                  b_r1_busy, b_r1_wreq, b_r1_rdata, b_r1_rv, b_r1_ed, b_r1_wd, b_r1_rdn};

  int total = 0;
  int bad   = 0;

  flash_arbiter #(.RR_EN(1'b1)) u_rr (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .r0_erase_all_i(r0_ea), .r0_erase_64k_i(r0_e64), .r0_erase_32k_i(r0_e32),
    .r0_erase_4k_i(r0_e4), .r0_wr_en_i(r0_wr), .r0_rd_en_i(r0_rd),
    .r0_addr_i(r0_addr), .r0_wr_data_i(r0_wd),
    .r0_busy_o(a_r0_busy), .r0_wr_req_o(a_r0_wreq), .r0_rd_data_o(a_r0_rdata),
    .r0_rd_data_valid_o(a_r0_rv), .r0_erase_done_o(a_r0_ed), .r0_wr_done_o(a_r0_wd),
    .r0_rd_done_o(a_r0_rdn),
    .r1_erase_all_i(r1_ea), .r1_erase_64k_i(r1_e64), .r1_erase_32k_i(r1_e32),
    .r1_erase_4k_i(r1_e4), .r1_wr_en_i(r1_wr), .r1_rd_en_i(r1_rd),
    .r1_addr_i(r1_addr), .r1_wr_data_i(r1_wd),
    .r1_busy_o(a_r1_busy), .r1_wr_req_o(a_r1_wreq), .r1_rd_data_o(a_r1_rdata),
    .r1_rd_data_valid_o(a_r1_rv), .r1_erase_done_o(a_r1_ed), .r1_wr_done_o(a_r1_wd),
    .r1_rd_done_o(a_r1_rdn),
    .flash_erase_all_o(a_ea), .flash_erase_64k_o(a_e64), .flash_erase_32k_o(a_e32),
    .flash_erase_4k_o(a_e4), .flash_wr_en_o(a_wr), .flash_rd_en_o(a_rd),
    .flash_addr_o(a_addr), .flash_wr_data_o(a_wdata),
    .flash_busy_i(f_busy), .flash_wr_req_i(f_wreq), .flash_rd_data_valid_i(f_rvalid),
    .flash_erase_done_i(f_edone), .flash_wr_done_i(f_wdone), .flash_rd_done_i(f_rdone),
    .flash_rd_data_i(f_rdata)
  );

  flash_arbiter #(.RR_EN(1'b0)) u_fp (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .r0_erase_all_i(r0_ea), .r0_erase_64k_i(r0_e64), .r0_erase_32k_i(r0_e32),
    .r0_erase_4k_i(r0_e4), .r0_wr_en_i(r0_wr), .r0_rd_en_i(r0_rd),
    .r0_addr_i(r0_addr), .r0_wr_data_i(r0_wd),
    .r0_busy_o(b_r0_busy), .r0_wr_req_o(b_r0_wreq), .r0_rd_data_o(b_r0_rdata),
    .r0_rd_data_valid_o(b_r0_rv), .r0_erase_done_o(b_r0_ed), .r0_wr_done_o(b_r0_wd),
    .r0_rd_done_o(b_r0_rdn),
    .r1_erase_all_i(r1_ea), .r1_erase_64k_i(r1_e64), .r1_erase_32k_i(r1_e32),
    .r1_erase_4k_i(r1_e4), .r1_wr_en_i(r1_wr), .r1_rd_en_i(r1_rd),
    .r1_addr_i(r1_addr), .r1_wr_data_i(r1_wd),
    .r1_busy_o(b_r1_busy), .r1_wr_req_o(b_r1_wreq), .r1_rd_data_o(b_r1_rdata),
    .r1_rd_data_valid_o(b_r1_rv), .r1_erase_done_o(b_r1_ed), .r1_wr_done_o(b_r1_wd),
    .r1_rd_done_o(b_r1_rdn),
    .flash_erase_all_o(b_ea), .flash_erase_64k_o(b_e64), .flash_erase_32k_o(b_e32),
    .flash_erase_4k_o(b_e4), .flash_wr_en_o(b_wr), .flash_rd_en_o(b_rd),
    .flash_addr_o(b_addr), .flash_wr_data_o(b_wdata),
    .flash_busy_i(f_busy), .flash_wr_req_i(f_wreq), .flash_rd_data_valid_i(f_rvalid),
    .flash_erase_done_i(f_edone), .flash_wr_done_i(f_wdone), .flash_rd_done_i(f_rdone),
    .flash_rd_data_i(f_rdata)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    int n0, n1, dmis;
    logic [7:0] wd;
    {r0_ea, r0_e64, r0_e32, r0_e4, r0_wr, r0_rd} = 6'b000000;
    {r1_ea, r1_e64, r1_e32, r1_e4, r1_wr, r1_rd} = 6'b000000;
    r0_addr = 24'h000000; r1_addr = 24'h000000;
    r0_wd = 8'h00; r1_wd = 8'h00; f_rdata = 8'h00;
    {f_busy, f_wreq, f_rvalid, f_edone, f_wdone, f_rdone} = 6'b000000;
    sys_rst_n = 1'b0;

    // reset state
    #12;
    chk("rst_out_rr", out_a, 96'd0);
    chk("rst_out_fp", out_b, 96'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    step();

    // r0 erase_4k
    r0_e4 = 1'b1; r0_addr = 24'h001000; #1;
    chk("e4k_idle_no_strobe", a_e4, 96'd0);
    step();
    chk("e4k_issue_strobe", a_e4, 96'd1);
    chk("e4k_issue_others", {a_ea, a_e64, a_e32, a_wr, a_rd}, 96'd0);
    chk("e4k_issue_addr", a_addr, 96'h001000);
    chk("e4k_issue_r0_busy", a_r0_busy, 96'd0);
    chk("e4k_issue_r1_busy", a_r1_busy, 96'd1);
    step();
    r0_e4 = 1'b0; f_busy = 1'b1; #1;
    chk("e4k_wait_strobe_low", a_e4, 96'd0);
    chk("e4k_wait_addr", a_addr, 96'h001000);
    chk("e4k_wait_r0_busy", a_r0_busy, 96'd1);
    chk("e4k_wait_r1_busy", a_r1_busy, 96'd1);
    f_edone = 1'b1; #1;
    chk("e4k_r0_done", a_r0_ed, 96'd1);
    chk("e4k_r1_no_done", a_r1_ed, 96'd0);
    step();
    f_edone = 1'b0; f_busy = 1'b0; #1;
    chk("e4k_rel_busy", {a_r0_busy, a_r1_busy}, 96'd3);
    chk("e4k_rel_no_done", a_r0_ed, 96'd0);
    step();
    chk("e4k_idle_busy", {a_r0_busy, a_r1_busy}, 96'd0);
    chk("e4k_idle_addr", a_addr, 96'd0);

    // reset during WAIT_DONE
    r1_rd = 1'b1; r1_addr = 24'h123456;
    step();
    chk("rst_issue_addr", a_addr, 96'h123456);
    step();
    r1_rd = 1'b0; f_rvalid = 1'b1; #1;
    chk("rst_wait_r1_valid", a_r1_rv, 96'd1);
    chk("rst_wait_r0_valid", a_r0_rv, 96'd0);
    sys_rst_n = 1'b0; #1;
    chk("rst_mid_out_rr", out_a, 96'd0);
    chk("rst_mid_out_fp", out_b, 96'd0);
    f_rvalid = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    step();
    f_rdone = 1'b1; #1;
    chk("rst_stray_done", {a_r0_rdn, a_r1_rdn}, 96'd0);
    chk("rst_stray_busy", {a_r0_busy, a_r1_busy}, 96'd0);
    f_rdone = 1'b0;

    // round-robin tie sequence from reset
    r0_rd = 1'b1; r1_rd = 1'b1; r0_addr = 24'hAAAAAA; r1_addr = 24'h555555;
    step();
    chk("rr1_addr_r0", a_addr, 96'hAAAAAA);
    chk("rr1_rd_fwd", a_rd, 96'd1);
    chk("rr1_r1_busy", a_r1_busy, 96'd1);
    step();
    r0_rd = 1'b0; f_rdone = 1'b1; #1;
    chk("rr1_done_route", {a_r0_rdn, a_r1_rdn}, 96'b10);
    step();
    f_rdone = 1'b0; #1;
    chk("rr1_rel_strobe", a_rd, 96'd0);
    chk("rr1_rel_busy", {a_r0_busy, a_r1_busy}, 96'd3);
    step();
    chk("rr1_idle_holdoff", a_rd, 96'd0);
    chk("rr1_idle_busy", a_r1_busy, 96'd0);
    step();
    chk("rr2_addr_r1", a_addr, 96'h555555);
    chk("rr2_rd_fwd", a_rd, 96'd1);
    chk("rr2_r0_busy", a_r0_busy, 96'd1);
    step();
    r1_rd = 1'b0; f_rdone = 1'b1; #1;
    chk("rr2_done_route", {a_r0_rdn, a_r1_rdn}, 96'b01);
    step();
    f_rdone = 1'b0;
    step();
    r0_rd = 1'b1; r1_rd = 1'b1; f_busy = 1'b1;
    step();
    chk("rr3_addr_r0", a_addr, 96'hAAAAAA);
    chk("rr3_busy_pass", {a_r0_busy, a_r1_busy}, 96'd3);

    // owner abandons while controller busy
    r0_rd = 1'b0; r1_rd = 1'b0; #1;
    chk("drop_strobe_low", a_rd, 96'd0);
    step();
    f_busy = 1'b0; f_rdone = 1'b1; #1;
    chk("drop_idle_busy", {a_r0_busy, a_r1_busy}, 96'd0);
    chk("drop_no_done", {a_r0_rdn, a_r1_rdn}, 96'd0);
    f_rdone = 1'b0;

    // r1 wr+rd together, done at acceptance ignored, 256 wr_req pulses
    r1_wr = 1'b1; r1_rd = 1'b1; r1_addr = 24'h0A0B0C;
    step();
    chk("wr_fwd_only", {a_wr, a_rd}, 96'b10);
    f_wdone = 1'b1; #1;
    chk("wr_done_at_accept", a_r1_wd, 96'd0);
    step();
    f_wdone = 1'b0; r1_wr = 1'b0; r1_rd = 1'b0; #1;
    chk("wr_in_wait_busy", a_r1_busy, 96'd0);
    chk("wr_in_wait_strobe", a_wr, 96'd0);
    n0 = 0; n1 = 0; dmis = 0;
    for (int i = 0; i < 256; i++) begin
      wd = 8'(i);
      r1_wd = wd; f_wreq = 1'b1; #1;
      if (a_r1_wreq === 1'b1) n1++;
      if (a_r0_wreq !== 1'b0) n0++;
      if (a_wdata !== wd) dmis++;
      step();
      f_wreq = 1'b0;
      step();
    end
    chk("wr_req_r1_count", n1, 96'd256);
    chk("wr_req_r0_count", n0, 96'd0);
    chk("wr_data_mismatches", dmis, 96'd0);
    f_wdone = 1'b1; #1;
    chk("wr_done_route", {a_r0_wd, a_r1_wd}, 96'b01);
    step();
    f_wdone = 1'b0;
    step();

    // fixed priority: r0 wins every grant; round-robin alternates
    r0_rd = 1'b1; r1_rd = 1'b1; r0_addr = 24'hAAAAAA; r1_addr = 24'h555555;
    for (int g = 0; g < 3; g++) begin
      step();
      chk("fp_addr_r0", b_addr, 96'hAAAAAA);
      chk("fp_r1_busy", b_r1_busy, 96'd1);
      chk("rr_alternates", a_addr, (g == 1) ? 96'h555555 : 96'hAAAAAA);
      step();
      f_rdone = 1'b1; #1;
      chk("fp_done_route", {b_r0_rdn, b_r1_rdn}, 96'b10);
      step();
      f_rdone = 1'b0;
      step();
    end
    r0_rd = 1'b0; r1_rd = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
